fetch_stage_ctrl: RTL and testbench

Owns the PC register and the IF/ID pipeline register of the five-stage MIPS pipeline, and applies the stall, flush and redirect requests produced by the hazard and flush logic. It selects the next PC from sequential fetch, EX-stage branch, ID-stage jump/jr, exception or interrupt vectors. It also latches external interrupts and records the exception PC (EPC).

---
 rtl/pipeline_defs.sv | 23 ++
 rtl/next_pc_mux.sv | 42 ++++
 rtl/fetch_stage_ctrl.sv | 95 +++++++++
 tb/tb_fetch_stage_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: fetch vectors, NOP encoding and PC source codes
// used by the fetch stage and by the hazard/flush units.
package pipeline_defs;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'b000,
    PCSRC_BRANCH = 3'b001,
    PCSRC_JR     = 3'b010,
    PCSRC_JUMP   = 3'b011,
    PCSRC_EXC    = 3'b101
  } pcsrc_e;

  // The kernel bit is excluded from the carry chain so user code never wraps into kernel space.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection for the fetch stage, including the
// branch/exception/interrupt decisions that also steer the IF/ID register.
module next_pc_mux
  import pipeline_defs::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_pc_write,
  input  logic [2:0]  i_id_pcsrc,
  input  logic [31:0] i_id_jr_target,
  input  logic [25:0] i_jump_field,
  input  logic [3:0]  i_jump_region,
  input  logic [2:0]  i_ex_pcsrc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_branch_target,
  input  logic        i_irq_pending,
  output logic [31:0] o_next_pc,
  output logic        o_branch_taken,
  output logic        o_irq_take,
  output logic        o_exc_take
);

  logic w_id_redirect;

  assign o_branch_taken = (i_ex_pcsrc == PCSRC_BRANCH) && i_ex_taken;
  assign w_id_redirect  = (i_id_pcsrc == PCSRC_JR) || (i_id_pcsrc == PCSRC_JUMP) ||
                          (i_id_pcsrc == PCSRC_EXC);
  // Interrupts only land in a slot no older control-flow change is claiming.
  assign o_irq_take     = i_irq_pending && !i_pc[31] && i_pc_write &&
                          !o_branch_taken && !w_id_redirect;
  assign o_exc_take     = i_pc_write && !o_branch_taken && (i_id_pcsrc == PCSRC_EXC);

  always_comb begin
    o_next_pc = pc_plus4(i_pc);
    if (o_branch_taken)                o_next_pc = i_ex_branch_target;
    else if (!i_pc_write)              o_next_pc = i_pc;
    else if (i_id_pcsrc == PCSRC_EXC)  o_next_pc = EXC_VEC;
    else if (i_id_pcsrc == PCSRC_JR)   o_next_pc = i_id_jr_target;
    else if (i_id_pcsrc == PCSRC_JUMP) o_next_pc = {i_jump_region, i_jump_field, 2'b00};
    else if (o_irq_take)               o_next_pc = IRQ_VEC;
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage of the five-stage MIPS pipeline: PC, IF/ID register, EPC and
// interrupt latch, driven by stall/flush/redirect requests from hazard logic.
module fetch_stage_ctrl
  import pipeline_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        IF_ID_Write,
  input  logic        IF_Flush,
  input  logic [31:0] Instruction,
  input  logic [2:0]  ID_PCSrc,
  input  logic [31:0] ID_JrTarget,
  input  logic [2:0]  EX_PCSrc,
  input  logic [31:0] EX_ALUOut,
  input  logic [31:0] EX_BranchTarget,
  input  logic        IRQ,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_Plus4,
  output logic [31:0] EPC,
  output logic        IRQ_Ack
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc_plus4;
  logic [31:0] r_epc;
  logic        r_irq_ack;
  logic        r_irq_pending;

  logic [31:0] w_next_pc;
  logic        w_branch_taken;
  logic        w_irq_take;
  logic        w_exc_take;
  logic        w_ifid_squash;
  logic        w_unused_aluout;

  assign w_unused_aluout = ^EX_ALUOut[31:1];

  next_pc_mux u_next_pc_mux (
    .i_pc               (r_pc),
    .i_pc_write         (PC_Write),
    .i_id_pcsrc         (ID_PCSrc),
    .i_id_jr_target     (ID_JrTarget),
    .i_jump_field       (r_ifid_instr[25:0]),
    .i_jump_region      (r_ifid_pc_plus4[31:28]),
    .i_ex_pcsrc         (EX_PCSrc),
    .i_ex_taken         (EX_ALUOut[0]),
    .i_ex_branch_target (EX_BranchTarget),
    .i_irq_pending      (r_irq_pending),
    .o_next_pc          (w_next_pc),
    .o_branch_taken     (w_branch_taken),
    .o_irq_take         (w_irq_take),
    .o_exc_take         (w_exc_take)
  );

  // A redirect squash beats an IF/ID stall; a stalled jump's IF_Flush does not.
  assign w_ifid_squash = w_branch_taken || (ID_PCSrc == PCSRC_EXC) || w_irq_take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP;
      r_ifid_pc_plus4 <= 32'h0;
      r_epc           <= 32'h0;
      r_irq_ack       <= 1'b0;
      r_irq_pending   <= 1'b0;
    end else begin
      r_pc      <= w_next_pc;
      r_irq_ack <= w_irq_take;

      if (w_exc_take)      r_epc <= r_ifid_pc_plus4 - 32'd4;
      else if (w_irq_take) r_epc <= r_pc;

      if (w_irq_take) r_irq_pending <= 1'b0;
      else if (IRQ)   r_irq_pending <= 1'b1;

      if (w_ifid_squash || (IF_ID_Write && IF_Flush)) begin
        r_ifid_instr    <= NOP;
        r_ifid_pc_plus4 <= 32'h0;
      end else if (IF_ID_Write) begin
        r_ifid_instr    <= Instruction;
        r_ifid_pc_plus4 <= pc_plus4(r_pc);
      end
    end
  end

  assign PC                = r_pc;
  assign IF_ID_Instruction = r_ifid_instr;
  assign IF_ID_PC_Plus4    = r_ifid_pc_plus4;
  assign EPC               = r_epc;
  assign IRQ_Ack           = r_irq_ack;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the fetch rules.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_Write, IF_ID_Write, IF_Flush, IRQ;
  logic [31:0] Instruction, ID_JrTarget, EX_ALUOut, EX_BranchTarget;
  logic [2:0]  ID_PCSrc, EX_PCSrc;
  logic [31:0] PC, IF_ID_Instruction, IF_ID_PC_Plus4, EPC;
  logic        IRQ_Ack;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_ins, m_p4, m_epc;
  logic        m_ack, m_pend;

  logic [2:0] id_codes [0:7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd3, 3'd5};
  logic [2:0] ex_codes [0:3] = '{3'd0, 3'd0, 3'd0, 3'd1};

  fetch_stage_ctrl dut (
    .clk(clk), .reset(reset), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_Flush(IF_Flush), .Instruction(Instruction), .ID_PCSrc(ID_PCSrc),
    .ID_JrTarget(ID_JrTarget), .EX_PCSrc(EX_PCSrc), .EX_ALUOut(EX_ALUOut),
    .EX_BranchTarget(EX_BranchTarget), .IRQ(IRQ), .PC(PC),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_Plus4(IF_ID_PC_Plus4),
    .EPC(EPC), .IRQ_Ack(IRQ_Ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inc4(input logic [31:0] p);
    logic [31:0] low;
    low = {1'b0, p[30:0]} + 32'd4;
    return {p[31], low[30:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc", PC, m_pc);
    check("ifid_instr", IF_ID_Instruction, m_ins);
    check("ifid_pc4", IF_ID_PC_Plus4, m_p4);
    check("epc", EPC, m_epc);
    check("irq_ack", {31'd0, IRQ_Ack}, {31'd0, m_ack});
  endtask

  task automatic m_reset();
    m_pc = 32'h8000_0000; m_ins = 0; m_p4 = 0; m_epc = 0; m_ack = 0; m_pend = 0;
  endtask

  // One clock of the reference model, then compare everything just after the edge.
  task automatic step();
    logic        bt, take, redirect_id;
    logic [31:0] npc, nins, np4, nepc;
    bt          = (EX_PCSrc == 3'd1) && EX_ALUOut[0];
    redirect_id = (ID_PCSrc == 3'd2) || (ID_PCSrc == 3'd3) || (ID_PCSrc == 3'd5);
    take        = m_pend && !m_pc[31] && PC_Write && !bt && !redirect_id;
    nepc = m_epc;
    if (bt)                     npc = EX_BranchTarget;
    else if (!PC_Write)         npc = m_pc;
    else if (ID_PCSrc == 3'd5) begin npc = 32'h8000_0008; nepc = m_p4 - 32'd4; end
    else if (ID_PCSrc == 3'd2)  npc = ID_JrTarget;
    else if (ID_PCSrc == 3'd3)  npc = {m_p4[31:28], m_ins[25:0], 2'b00};
    else if (take) begin npc = 32'h8000_0004; nepc = m_pc; end
    else                        npc = inc4(m_pc);
    if (bt || ID_PCSrc == 3'd5 || take) begin nins = 0; np4 = 0; end
    else if (!IF_ID_Write)      begin nins = m_ins; np4 = m_p4; end
    else if (IF_Flush)          begin nins = 0; np4 = 0; end
    else                        begin nins = Instruction; np4 = inc4(m_pc); end
    @(posedge clk);
    #1;
    m_pend = take ? 1'b0 : (IRQ ? 1'b1 : m_pend);
    m_pc = npc; m_ins = nins; m_p4 = np4; m_epc = nepc; m_ack = take;
    check_all();
  endtask

  task automatic set_idle();
    PC_Write = 1; IF_ID_Write = 1; IF_Flush = 0; IRQ = 0;
    ID_PCSrc = 0; EX_PCSrc = 0; EX_ALUOut = 0; EX_BranchTarget = 0; ID_JrTarget = 0;
    Instruction = 32'h2008_0001;
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    set_idle();
    EX_PCSrc = 3'd1; EX_ALUOut = 32'd1; EX_BranchTarget = tgt;
    step();
    set_idle();
  endtask

  initial begin
    set_idle();
    reset = 0;
    m_reset();
    #12;
    check("rst_pc", PC, 32'h8000_0000);
    check("rst_ifid", IF_ID_Instruction, 32'h0);
    check("rst_pc4", IF_ID_PC_Plus4, 32'h0);
    check("rst_epc", EPC, 32'h0);
    check("rst_ack", {31'd0, IRQ_Ack}, 32'd0);
    @(negedge clk); reset = 1;

    // Sequential fetch
    step(); check("seq_pc1", PC, 32'h8000_0004); check("seq_p4_1", IF_ID_PC_Plus4, 32'h8000_0004);
    step(); check("seq_pc2", PC, 32'h8000_0008); check("seq_p4_2", IF_ID_PC_Plus4, 32'h8000_0008);
    step(); step(); check("seq_pc4", PC, 32'h8000_0010);

    // Load-use stall
    PC_Write = 0; IF_ID_Write = 0;
    step(); step();
    check("stall_pc", PC, 32'h8000_0010); check("stall_p4", IF_ID_PC_Plus4, 32'h8000_0010);
    set_idle(); step(); check("resume_pc", PC, 32'h8000_0014);

    // Taken branch overriding the stall
    set_idle(); PC_Write = 0; IF_ID_Write = 0;
    EX_PCSrc = 3'd1; EX_ALUOut = 32'd1; EX_BranchTarget = 32'h8000_0100;
    step();
    check("br_pc", PC, 32'h8000_0100); check("br_nop", IF_ID_Instruction, 32'h0);

    // Jump with target field 0x40 from PC+4 0x24
    branch_to(32'h0000_0020);
    Instruction = 32'h0800_0040;
    step(); check("j_p4", IF_ID_PC_Plus4, 32'h0000_0024);
    set_idle(); ID_PCSrc = 3'd3; IF_Flush = 1;
    step(); check("j_pc", PC, 32'h0000_0100); check("j_nop", IF_ID_Instruction, 32'h0);

    // Interrupt taken from user PC 0x40
    branch_to(32'h0000_0040);
    PC_Write = 0; IF_ID_Write = 0; IRQ = 1;
    step();
    set_idle(); step();
    check("irq_pc", PC, 32'h8000_0004); check("irq_epc", EPC, 32'h0000_0040);
    check("irq_ack", {31'd0, IRQ_Ack}, 32'd1);
    step(); check("irq_ack_low", {31'd0, IRQ_Ack}, 32'd0);
    IRQ = 1; step(); IRQ = 0; step();
    check("kern_hold", {31'd0, IRQ_Ack}, 32'd0);
    branch_to(32'h0000_0200);
    step();
    check("irq2_pc", PC, 32'h8000_0004); check("irq2_epc", EPC, 32'h0000_0200);

    // Exception, then exception colliding with a taken branch
    branch_to(32'h0000_0054); step();
    ID_PCSrc = 3'd5; step();
    check("exc_pc", PC, 32'h8000_0008); check("exc_epc", EPC, 32'h0000_0054);
    branch_to(32'h0000_0070); step();
    ID_PCSrc = 3'd5; EX_PCSrc = 3'd1; EX_ALUOut = 32'd1; EX_BranchTarget = 32'h8000_0300;
    step();
    check("exc_br_pc", PC, 32'h8000_0300); check("exc_br_epc", EPC, 32'h0000_0054);

    // Kernel-bit preserving increment
    branch_to(32'hFFFF_FFFC); step(); check("wrap_k", PC, 32'h8000_0000);
    branch_to(32'h7FFF_FFFC); step(); check("wrap_u", PC, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      PC_Write        = ($urandom_range(0, 7) != 0);
      IF_ID_Write     = ($urandom_range(0, 7) != 0);
      IF_Flush        = ($urandom_range(0, 5) == 0);
      IRQ             = ($urandom_range(0, 9) == 0);
      Instruction     = $urandom;
      ID_PCSrc        = id_codes[$urandom_range(0, 7)];
      EX_PCSrc        = ex_codes[$urandom_range(0, 3)];
      EX_ALUOut       = $urandom;
      EX_BranchTarget = $urandom;
      ID_JrTarget     = $urandom & 32'h7FFF_FFFC;
      step();
    end

    // Asynchronous reset mid-operation
    set_idle();
    reset = 0;
    #1;
    m_reset();
    check_all();
    @(negedge clk); reset = 1;
    step(); check("post_rst_pc", PC, 32'h8000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
